id_stage: RTL

ID_STAGE -- requirements
Module: id_stage

---
 rtl/id_stage.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/id_stage.sv
// id_stage: instruction decode stage of a 5-stage MIPS-style pipeline.
//
// Decodes the fetched instruction into an 11-bit control word. It extracts
// the register indices and the sign-extended immediate, and reads operands
// from a 32-entry register file that has a write-through bypass for the
// writeback port. All results go into the ID/EX pipeline registers.
// A load-use hazard (stall) or a taken-branch mismatch in EX (redirect)
// makes the next edge load a bubble, which is control=0 and illegal=0.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   Instruction, PC4             fetched word and its PC+4
//   controlEX, writeRegEX        control word / destination of the EX instr
//   ALUresult, PC4EX             EX branch target and EX PC+4
//   regWriteWB, writeRegWB,
//   writeDataWB                  register-file write port
//   control, rs, rt, writeReg,
//   readData1, readData2,
//   signExtImm, PC4ID, illegal   registered ID/EX outputs
//   stall                        combinational load-use hazard flag
module id_stage #(
    parameter int SIZE = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [31:0]              Instruction,
    input  logic [SIZE-1:0]          PC4,
    input  logic [10:0]              controlEX,
    input  logic [$clog2(SIZE)-1:0]  writeRegEX,
    input  logic [SIZE-1:0]          ALUresult,
    input  logic [SIZE-1:0]          PC4EX,
    input  logic                     regWriteWB,
    input  logic [$clog2(SIZE)-1:0]  writeRegWB,
    input  logic [SIZE-1:0]          writeDataWB,
    output logic [10:0]              control,
    output logic [$clog2(SIZE)-1:0]  rs,
    output logic [$clog2(SIZE)-1:0]  rt,
    output logic [$clog2(SIZE)-1:0]  writeReg,
    output logic [SIZE-1:0]          readData1,
    output logic [SIZE-1:0]          readData2,
    output logic [SIZE-1:0]          signExtImm,
    output logic [SIZE-1:0]          PC4ID,
    output logic                     stall,
    output logic                     illegal
);

    localparam int AW = $clog2(SIZE);

    typedef enum logic [5:0] {
        OP_RTYPE = 6'b000000,
        OP_LW    = 6'b100011,
        OP_SW    = 6'b101011,
        OP_BEQ   = 6'b000100,
        OP_ADDI  = 6'b001000,
        OP_J     = 6'b000010
    } opcode_e;

    typedef struct packed {
        logic       jump;
        logic       branch;
        logic       mem_write;
        logic       mem_to_reg;
        logic       mem_read;
        logic       reg_write;
        logic       alu_src;
        logic       reg_dst;
        logic [2:0] alu_op;
    } ctrl_t;

    ctrl_t           dec;
    logic            dec_illegal;
    logic [AW-1:0]   rs_idx;
    logic [AW-1:0]   rt_idx;
    logic [AW-1:0]   rd_idx;
    logic [AW-1:0]   dest_idx;
    logic [SIZE-1:0] imm_ext;
    logic [SIZE-1:0] rd_data1;
    logic [SIZE-1:0] rd_data2;
    logic            redirect;
    logic            bubble;

    logic [SIZE-1:0] regs [SIZE];

    assign rs_idx  = Instruction[25:21];
    assign rt_idx  = Instruction[20:16];
    assign rd_idx  = Instruction[15:11];
    assign imm_ext = {{(SIZE-16){Instruction[15]}}, Instruction[15:0]};

    // Opcode decode
    always_comb begin
        dec         = '0;
        dec_illegal = 1'b0;
        case (Instruction[31:26])
            OP_RTYPE: begin
                dec.reg_write = 1'b1;
                dec.reg_dst   = 1'b1;
                dec.alu_op    = 3'b010;
            end
            OP_LW: begin
                dec.mem_read   = 1'b1;
                dec.mem_to_reg = 1'b1;
                dec.reg_write  = 1'b1;
                dec.alu_src    = 1'b1;
            end
            OP_SW: begin
                dec.mem_write = 1'b1;
                dec.alu_src   = 1'b1;
            end
            OP_BEQ: begin
                dec.branch = 1'b1;
                dec.alu_op = 3'b001;
            end
            OP_ADDI: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
            end
            OP_J: begin
                dec.jump = 1'b1;
            end
            default: begin
                dec_illegal = 1'b1;
            end
        endcase
    end

    assign dest_idx = dec.reg_dst ? rd_idx : rt_idx;

    // Register-file reads. Index 0 is hard-wired to zero. A same-cycle
    // writeback to the index being read is forwarded.
    always_comb begin
        if (rs_idx == '0)
            rd_data1 = '0;
        else if (regWriteWB && (writeRegWB == rs_idx))
            rd_data1 = writeDataWB;
        else
            rd_data1 = regs[rs_idx];

        if (rt_idx == '0)
            rd_data2 = '0;
        else if (regWriteWB && (writeRegWB == rt_idx))
            rd_data2 = writeDataWB;
        else
            rd_data2 = regs[rt_idx];
    end

    // A load in EX feeding a source register of a non-memory instruction.
    // writeRegEX == 0 deliberately still counts as a hazard.
    assign stall = controlEX[6] & ~dec.mem_read & ~dec.mem_write &
                   ((writeRegEX == rs_idx) | (writeRegEX == rt_idx));

    assign redirect = controlEX[9] & (ALUresult != PC4EX);
    assign bubble   = stall | redirect;

    // Register file. Reset wins over a writeback in the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < SIZE; i++)
                regs[i[AW-1:0]] <= '0;
        end else if (regWriteWB && (writeRegWB != '0)) begin
            regs[writeRegWB] <= writeDataWB;
        end
    end

    // ID/EX pipeline registers
    always_ff @(posedge clk) begin
        if (rst) begin
            control    <= '0;
            illegal    <= 1'b0;
            rs         <= '0;
            rt         <= '0;
            writeReg   <= '0;
            readData1  <= '0;
            readData2  <= '0;
            signExtImm <= '0;
            PC4ID      <= '0;
        end else begin
            control    <= bubble ? '0 : dec;
            illegal    <= ~bubble & dec_illegal;
            rs         <= rs_idx;
            rt         <= rt_idx;
            writeReg   <= dest_idx;
            readData1  <= rd_data1;
            readData2  <= rd_data2;
            signExtImm <= imm_ext;
            PC4ID      <= PC4;
        end
    end

endmodule
